byte_seq_ctrl: RTL

//  Sequencer for the byte-serial operand/result datapath. Gathers BYTES_IN operand bytes from an
//  8-bit valid/ready stream into a wide operand register, then pulses the datapath start and waits
//  for its done. It then returns the BYTES_OUT-byte result, LSB byte first, on an 8-bit valid/ready

---
 rtl/byte_seq_pkg.sv | 23 ++
 rtl/byte_seq_timer.sv | 39 +++
 rtl/byte_seq_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/byte_seq_pkg.sv
// rtl/byte_seq_pkg.sv - state encoding and size helpers for the byte sequencer
package byte_seq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam int DEFAULT_TIMEOUT = 255;

    // Bytes per transaction from its log2
    function automatic int bytes_of(input int log2_bytes);
        return 1 << log2_bytes;
    endfunction

    // One shared index register serves both the load and the drain phases
    function automatic int idx_width(input int log2_in, input int log2_out);
        int m;
        m = (log2_in > log2_out) ? log2_in : log2_out;
        return (m < 1) ? 1 : m;
    endfunction

endpackage

// File: rtl/byte_seq_timer.sv
// rtl/byte_seq_timer.sv - clear/enable idle counter that flags expiry at LIMIT idle cycles
module byte_seq_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Expiry is taken from the registered count only, so it never depends on clr
    assign expire = en && (count_q == W'(LIMIT - 1));

    // Clear wins over counting; the count parks at expiry until cleared
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !expire) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/byte_seq_ctrl.sv
// rtl/byte_seq_ctrl.sv - byte-serial operand gather / result drain sequencer (watchdog under BYTE_SEQ_TIMEOUT_EN)
module byte_seq_ctrl
    import byte_seq_pkg::*;
#(
    parameter int LOG2_BYTES_IN  = 3,
    parameter int LOG2_BYTES_OUT = 2,
    parameter int TIMEOUT        = DEFAULT_TIMEOUT
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [7:0]                            in_data,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    output logic [bytes_of(LOG2_BYTES_IN)*8-1:0]  dp_operand,
    output logic                                  dp_start,
    input  logic                                  dp_done,
    input  logic [bytes_of(LOG2_BYTES_OUT)*8-1:0] dp_result,
    output logic [7:0]                            out_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  busy,
    output logic                                  err
);

    localparam int BYTES_IN  = bytes_of(LOG2_BYTES_IN);
    localparam int BYTES_OUT = bytes_of(LOG2_BYTES_OUT);
    localparam int IDX_W     = idx_width(LOG2_BYTES_IN, LOG2_BYTES_OUT);

    localparam logic [IDX_W-1:0] IN_LAST  = IDX_W'(BYTES_IN - 1);
    localparam logic [IDX_W-1:0] OUT_LAST = IDX_W'(BYTES_OUT - 1);

    logic [1:0]             state_q,   state_d;
    logic [IDX_W-1:0]       idx_q,     idx_d;
    logic [BYTES_IN*8-1:0]  operand_q, operand_d;
    logic [BYTES_OUT*8-1:0] result_q,  result_d;
    logic [7:0]             out_data_q, out_data_d;
    logic                   first_q,   first_d;
    logic                   err_q,     err_d;

    logic                   in_fire;
    logic                   out_fire;
    logic                   abort;
    logic                   timeout_abort;
    logic [IDX_W-1:0]       wr_idx;
    logic [IDX_W-1:0]       nxt_idx;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // A watchdog range below one cycle is meaningless; keep the parameter referenced in both builds
    if (TIMEOUT < 1) begin : g_timeout_below_one
    end

`ifdef BYTE_SEQ_TIMEOUT_EN
    logic tmr_clr;
    logic tmr_en;

    // Any accepted byte or state change restarts the idle count; DRAIN stalls are legal backpressure
    assign tmr_clr = in_fire || (state_d != state_q);
    assign tmr_en  = (state_q == ST_LOAD) || (state_q == ST_EXEC);

    byte_seq_timer #(
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expire (abort)
    );
`else
    assign abort = 1'b0;
`endif

    // Real progress in the same cycle beats an expiring watchdog
    assign timeout_abort = abort &&
                           (((state_q == ST_LOAD) && !in_fire) ||
                            ((state_q == ST_EXEC) && !dp_done));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_fire) begin
                    state_d = (BYTES_IN == 1) ? ST_EXEC : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (in_fire && (idx_q == IN_LAST)) begin
                    state_d = ST_EXEC;
                end else if (timeout_abort) begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (dp_done) begin
                    state_d = ST_DRAIN;
                end else if (timeout_abort) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (out_fire && (idx_q == OUT_LAST)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode; out_data comes straight from its register so it is stable under stall
    always_comb begin
        in_ready   = (state_q == ST_IDLE) || (state_q == ST_LOAD);
        busy       = (state_q != ST_IDLE);
        dp_start   = (state_q == ST_EXEC) && first_q;
        out_valid  = (state_q == ST_DRAIN);
        out_data   = out_data_q;
        dp_operand = operand_q;
        err        = err_q;
    end

    // Datapath next values: byte index, operand/result capture and the pre-selected output byte
    always_comb begin
        idx_d      = idx_q;
        operand_d  = operand_q;
        result_d   = result_q;
        out_data_d = out_data_q;
        wr_idx     = (state_q == ST_IDLE) ? '0 : idx_q;
        nxt_idx    = (idx_q + 1'b1) & OUT_LAST;
        first_d    = (state_d == ST_EXEC) && (state_q != ST_EXEC);
        err_d      = timeout_abort;

        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (in_fire) begin
                    for (int i = 0; i < BYTES_IN; i++) begin
                        if (wr_idx == IDX_W'(i)) begin
                            operand_d[i*8 +: 8] = in_data;
                        end
                    end
                    if ((state_q == ST_IDLE) && (BYTES_IN > 1)) begin
                        idx_d = IDX_W'(1);
                    end else if ((state_q == ST_IDLE) || (idx_q == IN_LAST)) begin
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (timeout_abort) begin
                    idx_d = '0;
                end
            end
            ST_EXEC: begin
                if (dp_done) begin
                    result_d   = dp_result;
                    out_data_d = dp_result[7:0];
                    idx_d      = '0;
                end else if (timeout_abort) begin
                    idx_d = '0;
                end
            end
            ST_DRAIN: begin
                if (out_fire) begin
                    idx_d = (idx_q == OUT_LAST) ? '0 : idx_q + 1'b1;
                    for (int i = 0; i < BYTES_OUT; i++) begin
                        if (nxt_idx == IDX_W'(i)) begin
                            out_data_d = result_q[i*8 +: 8];
                        end
                    end
                end
            end
            default: idx_d = '0;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            operand_q  <= '0;
            result_q   <= '0;
            out_data_q <= '0;
            first_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            operand_q  <= operand_d;
            result_q   <= result_d;
            out_data_q <= out_data_d;
            first_q    <= first_d;
            err_q      <= err_d;
        end
    end

endmodule
